// File: rtl/io_pkg.sv
// Shared IO-space definitions: address selects for the output and input port blocks,
// plus the read-side decode used by the input register block.
package io_pkg;

  localparam int IO_DATA_W = 32;
  localparam int IO_NUM_IN = 3;

  // Output-port register selects (write side, addr[7:2])
  localparam logic [5:0] IO_OUT0_SEL = 6'b100000;
  localparam logic [5:0] IO_OUT1_SEL = 6'b100001;
  localparam logic [5:0] IO_OUT2_SEL = 6'b100010;

  // Input-port register selects (read side, addr[7:2])
  localparam logic [5:0] IO_IN0_SEL  = 6'b110000;
  localparam logic [5:0] IO_IN1_SEL  = 6'b110001;
  localparam logic [5:0] IO_IN2_SEL  = 6'b110010;
  localparam logic [5:0] IO_STAT_SEL = 6'b110011;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_IN0,
    RD_IN1,
    RD_IN2,
    RD_STAT
  } io_rd_sel_e;

  function automatic io_rd_sel_e io_rd_decode(input logic [5:0] sel);
    io_rd_sel_e rd_sel;
    case (sel)
      IO_IN0_SEL:  rd_sel = RD_IN0;
      IO_IN1_SEL:  rd_sel = RD_IN1;
      IO_IN2_SEL:  rd_sel = RD_IN2;
      IO_STAT_SEL: rd_sel = RD_STAT;
      default:     rd_sel = RD_NONE;
    endcase
    return rd_sel;
  endfunction

endpackage

// File: rtl/io_in_debounce.sv
// One input port: 2-flop synchroniser, candidate/counter debounce and committed value.
// commit_pulse is high in the cycle whose rising edge loads a new committed value.
module io_in_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                 io_clk,
  input  logic                 clrn,
  input  logic [IO_DATA_W-1:0] din,
  output logic [IO_DATA_W-1:0] dout,
  output logic                 commit_pulse
);

  logic [IO_DATA_W-1:0] s1_reg;
  logic [IO_DATA_W-1:0] s2_reg;
  logic [IO_DATA_W-1:0] committed_reg;

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign commit_pulse = (s2_reg != committed_reg);

      always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
          committed_reg <= '0;
        end else begin
          committed_reg <= s2_reg;
        end
      end
    end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [IO_DATA_W-1:0] cand_reg;
      logic [IO_DATA_W-1:0] cand_next;
      logic [IO_DATA_W-1:0] committed_next;
      logic [CNT_W-1:0]     cnt_reg;
      logic [CNT_W-1:0]     cnt_next;

      // Any movement of s2 restarts qualification; the counter only runs while a
      // stable candidate differs from the committed value, so it never passes CNT_LAST.
      always_comb begin
        cand_next      = cand_reg;
        cnt_next       = '0;
        committed_next = committed_reg;
        commit_pulse   = 1'b0;
        if (s2_reg != cand_reg) begin
          cand_next = s2_reg;
        end else if (cand_reg != committed_reg) begin
          if (cnt_reg == CNT_LAST) begin
            committed_next = cand_reg;
            commit_pulse   = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
          cand_reg      <= '0;
          cnt_reg       <= '0;
          committed_reg <= '0;
        end else begin
          cand_reg      <= cand_next;
          cnt_reg       <= cnt_next;
          committed_reg <= committed_next;
        end
      end
    end
  endgenerate

  assign dout = committed_reg;

endmodule

// File: rtl/io_input_reg.sv
// Memory-mapped input-port block: three debounced input buses, sticky change flags
// cleared by a CPU load of the status word, and an interrupt while any flag is set.
module io_input_reg
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic        io_clk,
  input  logic        clrn,
  input  logic [31:0] addr,
  input  logic        read_io_enable,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  output logic [31:0] dataout,
  output logic        io_irq
);

  logic [IO_DATA_W-1:0] port_din  [IO_NUM_IN];
  logic [IO_DATA_W-1:0] port_dout [IO_NUM_IN];
  logic [IO_NUM_IN-1:0] commit_pulse;
  logic [IO_NUM_IN-1:0] status_reg;
  logic [IO_NUM_IN-1:0] status_next;
  logic                 stat_clear;
  io_rd_sel_e           rd_sel;
  logic                 unused_addr;

  assign port_din[0] = in_port0;
  assign port_din[1] = in_port1;
  assign port_din[2] = in_port2;

  genvar gi;
  generate
    for (gi = 0; gi < IO_NUM_IN; gi++) begin : g_port
      io_in_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .io_clk      (io_clk),
        .clrn        (clrn),
        .din         (port_din[gi]),
        .dout        (port_dout[gi]),
        .commit_pulse(commit_pulse[gi])
      );
    end
  endgenerate

  assign rd_sel      = io_rd_decode(addr[7:2]);
  assign unused_addr = ^{addr[31:8], addr[1:0]};
  assign stat_clear  = read_io_enable && (rd_sel == RD_STAT);

  // A commit on the same edge as a clear must survive, so set is OR-ed after the clear.
  always_comb begin
    status_next = status_reg;
    if (stat_clear) begin
      status_next = '0;
    end
    status_next = status_next | commit_pulse;
  end

  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      status_reg <= '0;
    end else begin
      status_reg <= status_next;
    end
  end

  always_comb begin
    dataout = '0;
    case (rd_sel)
      RD_IN0:  dataout = port_dout[0];
      RD_IN1:  dataout = port_dout[1];
      RD_IN2:  dataout = port_dout[2];
      RD_STAT: dataout = {{(IO_DATA_W - IO_NUM_IN){1'b0}}, status_reg};
      default: dataout = '0;
    endcase
  end

  assign io_irq = |status_reg;

endmodule
